wt_mem_arbiter: RTL and testbench

Parametrised memory-side request arbiter and return router for the write-through cache subsystem. It merges NumPorts cache clients (I$, D$, and further clients such as a PTW or accelerator port) onto a single memory request channel. Each client has its own outstanding-transaction budget, and every return is routed back to the client that issued it. It replaces the fixed two-client (I$ plus D$) merge previously hard-wired into the memory adapters, and provides the subsystem busy indication.

---
 rtl/wt_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_wt_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_arbiter.sv
// wt_mem_arbiter: round-robin merge of NumPorts cache clients onto one
// registered memory request channel, with per-port outstanding budgets and
// routing of memory returns back to the issuing client.
module wt_mem_arbiter #(
    parameter int unsigned NumPorts       = 3,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned PortIdWidth    = $clog2(NumPorts)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             req_valid_i,
    output logic [NumPorts-1:0]             req_ready_o,
    input  logic [NumPorts*AddrWidth-1:0]   req_addr_i,
    input  logic [NumPorts*DataWidth-1:0]   req_data_i,
    input  logic [NumPorts-1:0]             req_write_i,
    input  logic [NumPorts*IdWidth-1:0]     req_id_i,
    output logic                            mem_req_valid_o,
    input  logic                            mem_req_ready_i,
    output logic [AddrWidth-1:0]            mem_req_addr_o,
    output logic [DataWidth-1:0]            mem_req_data_o,
    output logic                            mem_req_write_o,
    output logic [PortIdWidth+IdWidth-1:0]  mem_req_id_o,
    input  logic                            mem_rtrn_valid_i,
    input  logic [PortIdWidth+IdWidth-1:0]  mem_rtrn_id_i,
    input  logic [DataWidth-1:0]            mem_rtrn_data_i,
    output logic [NumPorts-1:0]             rtrn_valid_o,
    output logic [IdWidth-1:0]              rtrn_id_o,
    output logic [DataWidth-1:0]            rtrn_data_o,
    output logic                            busy_o,
    output logic                            err_o
);

    // A port granted at MaxOutstanding-1 can have a second request accepted
    // while the first still sits in the output register, so the count can
    // reach MaxOutstanding+1; size the counter for that.
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 2);

    logic [CntWidth-1:0]            cnt_q [NumPorts];
    logic [PortIdWidth-1:0]         rr_q;

    logic                           req_valid_q;
    logic [AddrWidth-1:0]           addr_q;
    logic [DataWidth-1:0]           data_q;
    logic                           write_q;
    logic [PortIdWidth+IdWidth-1:0] id_q;

    logic [NumPorts-1:0]            rtrn_valid_q;
    logic [IdWidth-1:0]             rtrn_id_q;
    logic [DataWidth-1:0]           rtrn_data_q;
    logic                           err_q;

    logic                           slot_free;
    logic                           mem_accept;
    logic [NumPorts-1:0]            eligible;
    logic [NumPorts-1:0]            grant;
    logic                           grant_any;
    logic [PortIdWidth-1:0]         grant_idx;
    int unsigned                    idx;

    logic [AddrWidth-1:0]           sel_addr;
    logic [DataWidth-1:0]           sel_data;
    logic                           sel_write;
    logic [IdWidth-1:0]             sel_id;

    logic [PortIdWidth-1:0]         acc_port;
    logic [PortIdWidth-1:0]         rtrn_port;
    logic [NumPorts-1:0]            acc_sel;
    logic [NumPorts-1:0]            ret_sel;
    logic                           rtrn_hit;
    logic                           any_cnt;

    assign slot_free  = !req_valid_q || mem_req_ready_i;
    assign mem_accept = req_valid_q && mem_req_ready_i;
    assign acc_port   = id_q[IdWidth +: PortIdWidth];
    assign rtrn_port  = mem_rtrn_id_i[IdWidth +: PortIdWidth];

    // Round-robin search over eligible ports starting at rr_q.
    always_comb begin
        eligible  = '0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            eligible[p] = req_valid_i[p] && (cnt_q[p] < CntWidth'(MaxOutstanding));
        end
        if (slot_free && !rst_i) begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                idx = (32'(rr_q) + i) % NumPorts;
                if (!grant_any && eligible[idx]) begin
                    grant_any  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = PortIdWidth'(idx);
                end
            end
        end
    end

    // Select the granted port's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        sel_write = 1'b0;
        sel_id    = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (grant[p]) begin
                sel_addr  = req_addr_i[p*AddrWidth +: AddrWidth];
                sel_data  = req_data_i[p*DataWidth +: DataWidth];
                sel_write = req_write_i[p];
                sel_id    = req_id_i[p*IdWidth +: IdWidth];
            end
        end
    end

    // Per-port acceptance and valid-return decode; returns to unknown ports
    // or ports with nothing outstanding are not routed.
    always_comb begin
        acc_sel  = '0;
        ret_sel  = '0;
        any_cnt  = 1'b0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            acc_sel[p] = mem_accept && (acc_port == PortIdWidth'(p));
            ret_sel[p] = mem_rtrn_valid_i && (rtrn_port == PortIdWidth'(p))
                         && (cnt_q[p] != '0);
            any_cnt    = any_cnt || (cnt_q[p] != '0);
        end
        rtrn_hit = |ret_sel;
    end

    // Outstanding-transaction counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                case ({acc_sel[p], ret_sel[p]})
                    2'b10:   cnt_q[p] <= cnt_q[p] + CntWidth'(1);
                    2'b01:   cnt_q[p] <= cnt_q[p] - CntWidth'(1);
                    default: cnt_q[p] <= cnt_q[p];
                endcase
            end
        end
    end

    // Output request register and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            id_q        <= '0;
            rr_q        <= '0;
        end else if (grant_any) begin
            req_valid_q <= 1'b1;
            addr_q      <= sel_addr;
            data_q      <= sel_data;
            write_q     <= sel_write;
            id_q        <= {grant_idx, sel_id};
            rr_q        <= PortIdWidth'((32'(grant_idx) + 1) % NumPorts);
        end else if (mem_accept) begin
            req_valid_q <= 1'b0;
        end
    end

    // Return strobe, broadcast id/data and sticky error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rtrn_valid_q <= '0;
            rtrn_id_q    <= '0;
            rtrn_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            rtrn_valid_q <= ret_sel;
            if (rtrn_hit) begin
                rtrn_id_q   <= mem_rtrn_id_i[IdWidth-1:0];
                rtrn_data_q <= mem_rtrn_data_i;
            end
            if (mem_rtrn_valid_i && !rtrn_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign req_ready_o     = grant;
    assign mem_req_valid_o = req_valid_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_data_o  = data_q;
    assign mem_req_write_o = write_q;
    assign mem_req_id_o    = id_q;
    assign rtrn_valid_o    = rtrn_valid_q;
    assign rtrn_id_o       = rtrn_id_q;
    assign rtrn_data_o     = rtrn_data_q;
    assign busy_o          = req_valid_q || any_cnt;
    assign err_o           = err_q;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Scoreboard bench for wt_mem_arbiter: a cycle-level reference model predicts
// grants and returns, queues expected memory requests and return strobes,
// and an independent monitor pops and compares them as the DUT presents them.
module tb_wt_mem_arbiter;

    localparam int NP = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int MO = 4;
    localparam int PW = 2;

    logic                 clk;
    logic                 rst;
    logic [NP-1:0]        req_valid_i;
    logic [NP-1:0]        req_ready_o;
    logic [NP*AW-1:0]     req_addr_i;
    logic [NP*DW-1:0]     req_data_i;
    logic [NP-1:0]        req_write_i;
    logic [NP*IW-1:0]     req_id_i;
    logic                 mem_req_valid_o;
    logic                 mem_req_ready_i;
    logic [AW-1:0]        mem_req_addr_o;
    logic [DW-1:0]        mem_req_data_o;
    logic                 mem_req_write_o;
    logic [PW+IW-1:0]     mem_req_id_o;
    logic                 mem_rtrn_valid_i;
    logic [PW+IW-1:0]     mem_rtrn_id_i;
    logic [DW-1:0]        mem_rtrn_data_i;
    logic [NP-1:0]        rtrn_valid_o;
    logic [IW-1:0]        rtrn_id_o;
    logic [DW-1:0]        rtrn_data_o;
    logic                 busy_o;
    logic                 err_o;

    wt_mem_arbiter #(
        .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW),
        .IdWidth(IW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_write_i(req_write_i), .req_id_i(req_id_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_write_o(mem_req_write_o), .mem_req_id_o(mem_req_id_o),
        .mem_rtrn_valid_i(mem_rtrn_valid_i), .mem_rtrn_id_i(mem_rtrn_id_i),
        .mem_rtrn_data_i(mem_rtrn_data_i),
        .rtrn_valid_o(rtrn_valid_o), .rtrn_id_o(rtrn_id_o),
        .rtrn_data_o(rtrn_data_o), .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
        logic             wr;
        logic [PW+IW-1:0] id;
    } req_t;

    typedef struct {
        int            cyc;
        int            port;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } ret_t;

    req_t reqq[$];
    ret_t rq[$];

    // Reference model state
    int m_cnt[NP];
    int m_rr;
    bit m_valid;
    int m_port;
    bit m_err;

    int cyc;
    int n_cmp;
    int n_bad;
    int p_req, p_rdy, p_rtrn, p_bad;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
        m_rr = 0; m_valid = 0; m_port = 0; m_err = 0;
        reqq.delete();
        rq.delete();
    endtask

    task automatic drive_random();
        for (int p = 0; p < NP; p++) begin
            req_valid_i[p] = ($urandom_range(99) < p_req);
            req_addr_i[p*AW +: AW] = {$urandom, $urandom};
            req_data_i[p*DW +: DW] = {$urandom, $urandom};
            req_write_i[p] = 1'($urandom);
            req_id_i[p*IW +: IW] = IW'($urandom);
        end
        mem_req_ready_i  = ($urandom_range(99) < p_rdy);
        mem_rtrn_valid_i = 1'b0;
        mem_rtrn_id_i    = '0;
        mem_rtrn_data_i  = {$urandom, $urandom};
        if ($urandom_range(99) < p_rtrn) begin
            if ($urandom_range(99) < p_bad) begin
                mem_rtrn_valid_i = 1'b1;
                mem_rtrn_id_i = {PW'($urandom_range(3)), IW'($urandom)};
            end else begin
                int s;
                s = $urandom_range(NP-1);
                for (int k = 0; k < NP; k++) begin
                    int q;
                    q = (s + k) % NP;
                    if (!mem_rtrn_valid_i && m_cnt[q] > 0) begin
                        mem_rtrn_valid_i = 1'b1;
                        mem_rtrn_id_i = {PW'(q), IW'($urandom)};
                    end
                end
            end
        end
    endtask

    // Compare per-cycle outputs against the model, then advance the model.
    task automatic check_cycle();
        bit busy;
        int g;
        bit accept;
        int q;
        bit routed;
        logic [NP-1:0] exp_rdy;
        busy = m_valid;
        for (int p = 0; p < NP; p++) if (m_cnt[p] > 0) busy = 1;
        chk("mem_req_valid", mem_req_valid_o, m_valid);
        chk("busy", busy_o, busy);
        chk("err", err_o, m_err);

        g = -1;
        if (!m_valid || mem_req_ready_i) begin
            for (int i = 0; i < NP; i++) begin
                int p;
                p = (m_rr + i) % NP;
                if (g < 0 && req_valid_i[p] && m_cnt[p] < MO) g = p;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready_o, exp_rdy);

        accept = m_valid && mem_req_ready_i;
        q = int'(mem_rtrn_id_i[IW +: PW]);
        routed = mem_rtrn_valid_i && q < NP && m_cnt[q] > 0;
        if (routed) begin
            ret_t r;
            r.cyc = cyc + 1; r.port = q;
            r.id = mem_rtrn_id_i[IW-1:0]; r.data = mem_rtrn_data_i;
            rq.push_back(r);
        end else if (mem_rtrn_valid_i) begin
            m_err = 1;
        end
        if (accept) m_cnt[m_port]++;
        if (routed) m_cnt[q]--;
        if (g >= 0) begin
            req_t e;
            e.addr = req_addr_i[g*AW +: AW];
            e.data = req_data_i[g*DW +: DW];
            e.wr   = req_write_i[g];
            e.id   = {PW'(g), req_id_i[g*IW +: IW]};
            reqq.push_back(e);
            m_valid = 1; m_port = g; m_rr = (g + 1) % NP;
        end else if (accept) begin
            m_valid = 0;
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            rst = 1'b1;
            req_valid_i = '1;
            mem_req_ready_i = 1'b1;
            mem_rtrn_valid_i = 1'b0;
            model_reset();
            #1;
            chk("rst_req_ready", req_ready_o, '0);
            chk("rst_mem_req_valid", mem_req_valid_o, 0);
            chk("rst_mem_req_addr", mem_req_addr_o, '0);
            chk("rst_mem_req_data", mem_req_data_o, '0);
            chk("rst_mem_req_write", mem_req_write_o, 0);
            chk("rst_mem_req_id", mem_req_id_o, '0);
            chk("rst_rtrn_valid", rtrn_valid_o, '0);
            chk("rst_rtrn_id", rtrn_id_o, '0);
            chk("rst_rtrn_data", rtrn_data_o, '0);
            chk("rst_busy", busy_o, 0);
            chk("rst_err", err_o, 0);
        end
    endtask

    task automatic run_phase(input int rq_, input int rd, input int rt, input int bd, input int n);
        p_req = rq_; p_rdy = rd; p_rtrn = rt; p_bad = bd;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            rst = 1'b0;
            drive_random();
            #1;
            check_cycle();
        end
    endtask

    // Monitor: compares accepted memory requests and return strobes.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (mem_req_valid_o && mem_req_ready_i) begin
                    if (reqq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL mem_req_unexpected @cyc %0d: got id %0h expected none", cyc, mem_req_id_o);
                    end else begin
                        req_t e;
                        e = reqq.pop_front();
                        chk("mem_req_addr", mem_req_addr_o, e.addr);
                        chk("mem_req_data", mem_req_data_o, e.data);
                        chk("mem_req_write", mem_req_write_o, e.wr);
                        chk("mem_req_id", mem_req_id_o, e.id);
                    end
                end
                while (rq.size() > 0 && rq[0].cyc < cyc) begin
                    ret_t m;
                    m = rq.pop_front();
                    n_cmp++; n_bad++;
                    $display("FAIL rtrn_missing @cyc %0d: got no strobe expected port %0d at cyc %0d", cyc, m.port, m.cyc);
                end
                if (rtrn_valid_o != '0) begin
                    if (rq.size() == 0 || rq[0].cyc != cyc) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rtrn_unexpected @cyc %0d: got strobe %b expected none", cyc, rtrn_valid_o);
                    end else begin
                        ret_t r;
                        logic [NP-1:0] oh;
                        r = rq.pop_front();
                        oh = '0;
                        oh[r.port] = 1'b1;
                        chk("rtrn_valid", rtrn_valid_o, oh);
                        chk("rtrn_id", rtrn_id_o, r.id);
                        chk("rtrn_data", rtrn_data_o, r.data);
                    end
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1;
        req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
        req_write_i = '0; req_id_i = '0;
        mem_req_ready_i = 1'b0; mem_rtrn_valid_i = 1'b0;
        mem_rtrn_id_i = '0; mem_rtrn_data_i = '0;
        model_reset();
        reset_cycles(3);

        // Single request on port 1, id 5, addr 0x1000.
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        req_valid_i = 3'b010;
        req_addr_i[AW +: AW] = 64'h1000;
        req_id_i[IW +: IW] = 4'd5;
        req_write_i = '0;
        mem_req_ready_i = 1'b1;
        mem_rtrn_valid_i = 1'b0;
        #1;
        check_cycle();
        run_phase(0, 100, 0, 0, 3);

        run_phase(100, 100, 0, 0, 12);
        run_phase(100, 100, 60, 0, 200);
        run_phase(80, 30, 40, 0, 300);
        run_phase(100, 100, 10, 0, 200);
        run_phase(60, 70, 50, 20, 300);
        reset_cycles(2);
        run_phase(0, 100, 100, 100, 20);
        run_phase(70, 80, 50, 10, 300);
        run_phase(0, 100, 0, 0, 6);

        chk("reqq_drained", reqq.size(), 0);
        chk("rq_drained", rq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
